mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4, which is the number of consecutive cycles requester 1 may be denied before it is forced a grant (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports req0_valid, req1_valid, input, 1 bit each: a request is pending (0 = core data port, 1 = DMA/loader).
REQ-005 The module SHALL have ports req0_ready, req1_ready, output, 1 bit each: the request is accepted this cycle.
REQ-006 The module SHALL have ports reqN_we (input, 1 bit), reqN_addr (input, 32 bits), reqN_wdata (input, 32 bits) and reqN_be (input, 4 bits): write flag, byte address, write data and byte enables.
REQ-007 The module SHALL have ports rsp0_valid, rsp1_valid, output, 1 bit each: read data is valid.
REQ-008 The module SHALL have ports rsp0_rdata, rsp1_rdata, output, 32 bits each: read data.
REQ-009 The module SHALL have ports mem_addr, mem_wr_addr and mem_wr_data, output, 32 bits each: read address, write address and write data driven to the shared BRAM port.
REQ-010 The module SHALL have ports mem_wr_en (output, 1 bit) and mem_byte_en (output, 4 bits): BRAM write strobe and byte lanes.
REQ-011 The module SHALL have port mem_rd_data, input, 32 bits: BRAM read data, valid one cycle after mem_addr is presented.

Function
REQ-012 Grant SHALL be combinational from the valids and the starvation state, with at most one grant per cycle.
REQ-013 Priority: requester 0 wins by default; requester 1 wins when starve_cnt == STARVE_LIMIT or req0_valid == 0.
REQ-014 reqN_ready SHALL equal grantN; a transfer occurs when valid && ready, and requesters hold all request fields stable until ready.
REQ-015 When granted, the mux SHALL drive mem_addr = mem_wr_addr = reqN_addr, mem_wr_data = reqN_wdata, mem_wr_en = reqN_we, and mem_byte_en = reqN_be when reqN_we, else 4'b0000.
REQ-016 With no grant, mem_wr_en = 0, mem_byte_en = 0, mem_addr = mem_wr_addr = mem_wr_data = 0.
REQ-017 starve_cnt (4-bit register) SHALL increment when req1_valid && !grant1 and clear to 0 on grant1 or !req1_valid.
REQ-018 starve_cnt SHALL saturate at STARVE_LIMIT.
REQ-019 A granted read (we = 0) SHALL set rsp_pend = 1 and rsp_tag = N at the next edge; otherwise rsp_pend SHALL clear.
REQ-020 rspN_valid SHALL equal rsp_pend && rsp_tag == N, giving exactly 1-cycle read latency and at most one response per cycle.
REQ-021 rspN_rdata SHALL equal mem_rd_data when rspN_valid, else 32'h0.
REQ-022 Writes SHALL produce no response; a write accepted in the cycle after a read SHALL NOT suppress that read's response.
REQ-023 Back-to-back reads from either requester SHALL sustain one grant per cycle, with no bubble.
REQ-024 If both requesters are valid in the same cycle, exactly one is granted; the loser's ready stays 0 and its request persists.

Reset
REQ-025 While rst_n = 0: starve_cnt = 0, rsp_pend = 0, rsp_tag = 0, rsp0_valid = rsp1_valid = 0, and rsp data = 0.
REQ-026 While rst_n = 0: req0_ready = req1_ready = 0 and mem_wr_en = 0, regardless of the valids.
REQ-027 A read accepted in the cycle reset asserts SHALL yield no response after reset deasserts.

Verification
REQ-028 Scenario: req0 read 0x100 alone, BRAM returns 0xDEADBEEF -> req0_ready = 1 in cycle T; rsp0_valid = 1 with rdata 0xDEADBEEF at T+1; rsp1_valid stays 0.
REQ-029 Scenario: both valid continuously, STARVE_LIMIT = 4 -> grants follow 0,0,0,0,1,0,0,0,0,1, with starve_cnt sequence 1,2,3,4,0.
REQ-030 Scenario: req1 write addr 0x40, data 0x12345678, be 4'b0011, req0 idle -> mem_wr_en = 1, mem_byte_en = 4'b0011, mem_wr_data = 0x12345678; no rsp.
REQ-031 Scenario: req0 read at T, req1 write at T+1 -> rsp0_valid = 1 at T+1 while mem_wr_en = 1 for req1 in the same cycle.
REQ-032 Scenario: req0 read accepted, rst_n pulsed low mid-cycle before the edge -> rsp0_valid = 0 immediately and stays 0 after release.
REQ-033 Scenario: req0 read with be = 4'b1111 -> mem_byte_en = 4'b0000 and mem_wr_en = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter in front of a single shared BRAM port.
//   Requester 0 (core data port) has default priority; requester 1
//   (DMA/loader) is forced a grant after STARVE_LIMIT consecutive denials.
//   Reads return data one cycle after the grant on the matching rspN port.
// Ports
//   clk, rst_n                     : clock, asynchronous active-low reset
//   reqN_valid/ready               : request handshake (N = 0, 1)
//   reqN_we/addr/wdata/be          : request fields
//   rspN_valid/rdata               : read response
//   mem_addr/wr_addr/wr_data       : BRAM address and write data
//   mem_wr_en/byte_en              : BRAM write strobe and lanes
//   mem_rd_data                    : BRAM read data (1-cycle latency)
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_be,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_be,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rd_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       rsp_pend_q, rsp_pend_d;
  logic       rsp_tag_q, rsp_tag_d;
  logic       grant0, grant1;
  logic       starved;

  assign starved = (starve_q == LIMIT);

  // Grants are masked by rst_n so nothing is accepted while reset is held,
  // which also keeps a read presented at reset from producing a response.
  always_comb begin
    grant1 = rst_n && req1_valid && (!req0_valid || starved);
    grant0 = rst_n && req0_valid && !grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    mem_addr    = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    mem_byte_en = '0;
    if (grant0) begin
      mem_addr    = req0_addr;
      mem_wr_addr = req0_addr;
      mem_wr_data = req0_wdata;
      mem_wr_en   = req0_we;
      mem_byte_en = req0_we ? req0_be : 4'b0000;
    end else if (grant1) begin
      mem_addr    = req1_addr;
      mem_wr_addr = req1_addr;
      mem_wr_data = req1_wdata;
      mem_wr_en   = req1_we;
      mem_byte_en = req1_we ? req1_be : 4'b0000;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!req1_valid || grant1) begin
      starve_d = '0;
    end else if (starve_q < LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Only a granted read arms a response; a following write simply clears
  // the flag for the next cycle, after the read's response has been shown.
  always_comb begin
    rsp_pend_d = (grant0 && !req0_we) || (grant1 && !req1_we);
    rsp_tag_d  = grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      rsp_pend_q <= 1'b0;
      rsp_tag_q  <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

  assign rsp0_valid = rsp_pend_q && !rsp_tag_q;
  assign rsp1_valid = rsp_pend_q && rsp_tag_q;
  assign rsp0_rdata = rsp0_valid ? mem_rd_data : '0;
  assign rsp1_rdata = rsp1_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter: a reference model predicts the
//   grant and BRAM mux outputs each cycle and pushes expected read responses
//   into a queue that is popped on the following cycle.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_be;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_be;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_wr_addr, mem_wr_data;
  logic        mem_wr_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rd_data = '0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_be(req0_be),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_be(req1_be),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bram_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous-read BRAM stand-in: data appears one cycle after the address.
  always @(posedge clk) mem_rd_data <= bram_val(mem_addr);

  typedef struct { logic tag; logic [31:0] data; } rsp_t;
  rsp_t rsp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned m_starve = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check combinational and
  // response outputs, push any new read expectation, advance the model.
  task automatic cycle(input logic v0, input logic we0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic [3:0] be0,
                       input logic v1, input logic we1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [3:0] be1);
    logic g0, g1, xwe;
    logic [31:0] xa, xd;
    logic [3:0] xbe;
    rsp_t e;
    @(negedge clk);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0; req0_be = be0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1; req1_be = be1;
    #1;
    g1 = v1 && (!v0 || m_starve == LIMIT);
    g0 = v0 && !g1;
    xa = g0 ? a0 : (g1 ? a1 : '0);
    xd = g0 ? d0 : (g1 ? d1 : '0);
    xwe = g0 ? we0 : (g1 ? we1 : 1'b0);
    xbe = xwe ? (g0 ? be0 : be1) : 4'b0000;
    check_eq("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
    check_eq("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
    check_eq("mem_addr", mem_addr, xa);
    check_eq("mem_wr_addr", mem_wr_addr, xa);
    check_eq("mem_wr_data", mem_wr_data, xd);
    check_eq("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, xwe});
    check_eq("mem_byte_en", {28'b0, mem_byte_en}, {28'b0, xbe});
    if (rsp_q.size() != 0) begin
      e = rsp_q.pop_front();
      check_eq("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, !e.tag});
      check_eq("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, e.tag});
      check_eq("rsp0_rdata", rsp0_rdata, e.tag ? 32'h0 : e.data);
      check_eq("rsp1_rdata", rsp1_rdata, e.tag ? e.data : 32'h0);
    end else begin
      check_eq("rsp0_valid_idle", {31'b0, rsp0_valid}, 32'h0);
      check_eq("rsp1_valid_idle", {31'b0, rsp1_valid}, 32'h0);
      check_eq("rsp0_rdata_idle", rsp0_rdata, 32'h0);
      check_eq("rsp1_rdata_idle", rsp1_rdata, 32'h0);
    end
    if ((g0 || g1) && !xwe) begin
      e.tag = g1;
      e.data = bram_val(xa);
      rsp_q.push_back(e);
    end
    @(posedge clk);
    if (!v1 || g1) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t e;
    // Reset held with both requesters asserting writes: nothing is accepted.
    rst_n = 1'b0;
    req0_valid = 1; req0_we = 1; req0_addr = 32'h10; req0_wdata = 32'h1; req0_be = 4'hF;
    req1_valid = 1; req1_we = 1; req1_addr = 32'h20; req1_wdata = 32'h2; req1_be = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req0_ready", {31'b0, req0_ready}, 32'h0);
    check_eq("rst_req1_ready", {31'b0, req1_ready}, 32'h0);
    check_eq("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
    check_eq("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
    check_eq("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
    check_eq("rst_rsp0_rdata", rsp0_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Single read from requester 0 returning 0xDEADBEEF next cycle.
    cycle(1, 0, 32'h100, '0, 4'hF, 0, 0, '0, '0, '0);
    idle();

    // Both requesting reads continuously: 0,0,0,0,1 pattern twice, no bubbles.
    for (int i = 0; i < 10; i++)
      cycle(1, 0, 32'h200, '0, 4'hF, 1, 0, 32'h300, '0, 4'hF);
    idle();

    // Requester 1 write alone, partial byte lanes, no response.
    cycle(0, 0, '0, '0, '0, 1, 1, 32'h40, 32'h12345678, 4'b0011);
    idle();

    // Read on 0 followed by write on 1: response coexists with the write.
    cycle(1, 0, 32'h104, '0, 4'hF, 0, 0, '0, '0, '0);
    cycle(0, 0, '0, '0, '0, 1, 1, 32'h44, 32'hCAFEF00D, 4'b1100);
    idle();

    // Read with all byte enables set still drives no write lanes.
    cycle(1, 0, 32'h108, 32'hFFFFFFFF, 4'b1111, 0, 0, '0, '0, '0);
    idle();

    // Requester 1 reads alone, then starvation with writes from 1.
    cycle(0, 0, '0, '0, '0, 1, 0, 32'h400, '0, 4'h0);
    for (int i = 0; i < 6; i++)
      cycle(1, 0, 32'h210, '0, 4'hF, 1, 1, 32'h410, 32'h55AA55AA, 4'b1010);
    idle();

    // Randomised mix.
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom), 1'($urandom), $urandom & 32'hFFFC, $urandom, 4'($urandom),
            1'($urandom), 1'($urandom), $urandom & 32'hFFFC, $urandom, 4'($urandom));
    idle();

    // Reset pulsed mid-cycle while a read is being accepted and another's
    // response is being shown.
    cycle(1, 0, 32'h500, '0, 4'hF, 0, 0, '0, '0, '0);
    @(negedge clk);
    req0_valid = 1; req0_we = 0; req0_addr = 32'h600;
    req1_valid = 0;
    #1;
    e = rsp_q.pop_front();
    check_eq("pre_rst_req0_ready", {31'b0, req0_ready}, 32'h1);
    check_eq("pre_rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
    check_eq("pre_rst_rsp0_rdata", rsp0_rdata, e.data);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
    check_eq("mid_rst_rsp0_rdata", rsp0_rdata, 32'h0);
    check_eq("mid_rst_req0_ready", {31'b0, req0_ready}, 32'h0);
    check_eq("mid_rst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
    rsp_q.delete();
    m_starve = 0;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    rst_n = 1'b1;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
